// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: three coin denominations, a credit register,
// vend handshake and change pulse stream. Optional stock counter: VEND_STOCK_EN.
// Ports: clk, rst (async, active-high); coin_valid/coin_sel, cancel, vend_ack,
//   chg_ack in; credit, coin_accept, coin_reject, vend_req, chg_req, busy out;
//   with VEND_STOCK_EN also restock in, sold_out out.
module vend_ctrl_param #(
  parameter int CREDIT_W   = 6,
  parameter int PRICE      = 15,
  parameter int COIN_A_VAL = 5,
  parameter int COIN_B_VAL = 10,
  parameter int COIN_C_VAL = 25,
  parameter int CHG_UNIT   = 5
`ifdef VEND_STOCK_EN
  ,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 10
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_sel,
  input  logic                cancel,
  input  logic                vend_ack,
  input  logic                chg_ack,
`ifdef VEND_STOCK_EN
  input  logic                restock,
  output logic                sold_out,
`endif
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic                vend_req,
  output logic                chg_req,
  output logic                busy
);

  localparam int CW = CREDIT_W + 1;
  localparam logic [CW-1:0] MAX_C   = CW'((1 << CREDIT_W) - 1);
  localparam logic [CW-1:0] PRICE_W = CW'(PRICE);
  localparam logic [CW-1:0] CHG_C   = CW'(CHG_UNIT);
  localparam logic [CW-1:0] VAL_A   = CW'(COIN_A_VAL);
  localparam logic [CW-1:0] VAL_B   = CW'(COIN_B_VAL);
  localparam logic [CW-1:0] VAL_C   = CW'(COIN_C_VAL);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  typedef enum logic [1:0] {
    IDLE, COLLECT, VEND, CHANGE
  } state_t;

  state_t state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [CW-1:0] coin_val, sum;
  logic acc_nxt, rej_nxt, vend_done;
  logic coin_bad, sold_block;

  always_comb begin
    coin_val = '0;
    unique case (coin_sel)
      2'b00:   coin_val = VAL_A;
      2'b01:   coin_val = VAL_B;
      2'b10:   coin_val = VAL_C;
      default: coin_val = '0;
    endcase
  end

  // one extra bit so an overflowing sum is caught rather than wrapped
  assign sum = {1'b0, credit} + coin_val;
  assign coin_bad = (coin_sel == 2'b11) || (sum > MAX_C) || sold_block;

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    acc_nxt    = 1'b0;
    rej_nxt    = 1'b0;
    vend_done  = 1'b0;
    unique case (state)
      IDLE, COLLECT: begin
        if (cancel && state == COLLECT) begin
          state_nxt = CHANGE;
          rej_nxt   = coin_valid;
        end else if (coin_valid) begin
          if (coin_bad) begin
            rej_nxt = 1'b1;
          end else begin
            acc_nxt    = 1'b1;
            credit_nxt = sum[CREDIT_W-1:0];
            state_nxt  = (sum >= PRICE_W) ? VEND : COLLECT;
          end
        end
      end
      VEND: begin
        rej_nxt = coin_valid;
        if (vend_ack) begin
          vend_done  = 1'b1;
          credit_nxt = credit - PRICE_C;
          state_nxt  = (credit_nxt != '0) ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        rej_nxt = coin_valid;
        if (credit == '0) begin
          state_nxt = IDLE;
        end else if (chg_ack) begin
          if ({1'b0, credit} <= CHG_C) begin
            credit_nxt = '0;
            state_nxt  = IDLE;
          end else begin
            credit_nxt = credit - CHG_C[CREDIT_W-1:0];
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= '0;
      coin_accept <= 1'b0;
      coin_reject <= 1'b0;
      vend_req    <= 1'b0;
      chg_req     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      coin_accept <= acc_nxt;
      coin_reject <= rej_nxt;
      vend_req    <= (state_nxt == VEND);
      chg_req     <= (state_nxt == CHANGE) && (credit_nxt != '0);
      busy        <= (state_nxt == VEND) || (state_nxt == CHANGE);
    end
  end

`ifdef VEND_STOCK_EN
  localparam logic [STOCK_W-1:0] STOCK_C = STOCK_W'(STOCK_INIT);

  logic [STOCK_W-1:0] stock, stock_nxt;

  // restock beats a same-cycle vend decrement
  always_comb begin
    stock_nxt = stock;
    if (restock)
      stock_nxt = STOCK_C;
    else if (vend_done && stock != '0)
      stock_nxt = stock - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stock    <= STOCK_C;
      sold_out <= (STOCK_C == '0);
    end else begin
      stock    <= stock_nxt;
      sold_out <= (stock_nxt == '0);
    end
  end

  assign sold_block = sold_out;
`else
  assign sold_block = 1'b0;
`endif

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed bench for vend_ctrl_param: default instance, a CREDIT_W=5/PRICE=31
// instance, and a STOCK_INIT=1 instance when VEND_STOCK_EN is defined.
module tb_vend_ctrl_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  logic a_cv, a_can, a_va, a_ca;
  logic [1:0] a_sel;
  logic [5:0] a_cr;
  logic a_acc, a_rej, a_vr, a_chr, a_busy;

  logic b_cv, b_can, b_va, b_ca;
  logic [1:0] b_sel;
  logic [4:0] b_cr;
  logic b_acc, b_rej, b_vr, b_chr, b_busy;

  vend_ctrl_param dut_a (
    .clk(clk), .rst(rst),
    .coin_valid(a_cv), .coin_sel(a_sel), .cancel(a_can),
    .vend_ack(a_va), .chg_ack(a_ca),
`ifdef VEND_STOCK_EN
    .restock(1'b0), .sold_out(),
`endif
    .credit(a_cr), .coin_accept(a_acc), .coin_reject(a_rej),
    .vend_req(a_vr), .chg_req(a_chr), .busy(a_busy)
  );

  vend_ctrl_param #(.CREDIT_W(5), .PRICE(31)) dut_b (
    .clk(clk), .rst(rst),
    .coin_valid(b_cv), .coin_sel(b_sel), .cancel(b_can),
    .vend_ack(b_va), .chg_ack(b_ca),
`ifdef VEND_STOCK_EN
    .restock(1'b0), .sold_out(),
`endif
    .credit(b_cr), .coin_accept(b_acc), .coin_reject(b_rej),
    .vend_req(b_vr), .chg_req(b_chr), .busy(b_busy)
  );

`ifdef VEND_STOCK_EN
  logic c_cv, c_va, c_ca, c_rs, c_so;
  logic [1:0] c_sel;
  logic [5:0] c_cr;
  logic c_acc, c_rej, c_vr, c_chr, c_busy;

  vend_ctrl_param #(.STOCK_INIT(1)) dut_c (
    .clk(clk), .rst(rst),
    .coin_valid(c_cv), .coin_sel(c_sel), .cancel(1'b0),
    .vend_ack(c_va), .chg_ack(c_ca),
    .restock(c_rs), .sold_out(c_so),
    .credit(c_cr), .coin_accept(c_acc), .coin_reject(c_rej),
    .vend_req(c_vr), .chg_req(c_chr), .busy(c_busy)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_clr();
    a_cv = 0; a_sel = 0; a_can = 0; a_va = 0; a_ca = 0;
  endtask

  task automatic a_coin(input logic [1:0] s);
    a_cv = 1; a_sel = s;
    tick();
    a_clr();
  endtask

  task automatic b_coin(input logic [1:0] s);
    b_cv = 1; b_sel = s;
    tick();
    b_cv = 0; b_sel = 0;
  endtask

  initial begin
    a_clr();
    b_cv = 0; b_sel = 0; b_can = 0; b_va = 0; b_ca = 0;
`ifdef VEND_STOCK_EN
    c_cv = 0; c_sel = 0; c_va = 0; c_ca = 0; c_rs = 0;
`endif
    #12;
    chk("rst_credit", a_cr, 0);
    chk("rst_outs", {a_acc, a_rej, a_vr, a_chr, a_busy}, 0);
    rst = 0;
    tick();

    // A then B reaches price exactly
    a_coin(2'b00);
    chk("t1_acc", a_acc, 1);
    chk("t1_cr5", a_cr, 5);
    chk("t1_vr0", a_vr, 0);
    a_coin(2'b01);
    chk("t1_cr15", a_cr, 15);
    chk("t1_vr", a_vr, 1);
    chk("t1_busy", a_busy, 1);
    tick();
    chk("t1_accpulse", a_acc, 0);
    chk("t1_vrhold", a_vr, 1);
    a_va = 1; tick(); a_clr();
    chk("t1_cr0", a_cr, 0);
    chk("t1_vrdrop", a_vr, 0);
    chk("t1_nochg", a_chr, 0);
    chk("t1_idle", a_busy, 0);

    // C coin, vend, two change units
    a_coin(2'b10);
    chk("t2_cr25", a_cr, 25);
    chk("t2_vr", a_vr, 1);
    a_va = 1; tick(); a_clr();
    chk("t2_cr10", a_cr, 10);
    chk("t2_chr", a_chr, 1);
    chk("t2_vr0", a_vr, 0);
    a_ca = 1; tick();
    chk("t2_cr5", a_cr, 5);
    chk("t2_chr1", a_chr, 1);
    tick(); a_clr();
    chk("t2_cr0", a_cr, 0);
    chk("t2_chr0", a_chr, 0);
    chk("t2_busy0", a_busy, 0);

    // cancel with simultaneous coin: refund, coin rejected
    a_coin(2'b00);
    chk("t3_cr5", a_cr, 5);
    a_can = 1; a_cv = 1; a_sel = 2'b01;
    tick(); a_clr();
    chk("t3_rej", a_rej, 1);
    chk("t3_acc0", a_acc, 0);
    chk("t3_cr5b", a_cr, 5);
    chk("t3_chr", a_chr, 1);
    chk("t3_vr0", a_vr, 0);
    a_ca = 1; tick(); a_clr();
    chk("t3_cr0", a_cr, 0);
    chk("t3_chr0", a_chr, 0);
    chk("t3_vr0b", a_vr, 0);

    // invalid denomination and coin during VEND
    a_coin(2'b11);
    chk("t4_rej11", a_rej, 1);
    chk("t4_cr0", a_cr, 0);
    a_coin(2'b10);
    chk("t4_vend", a_vr, 1);
    a_coin(2'b00);
    chk("t4_rejv", a_rej, 1);
    chk("t4_cr25", a_cr, 25);
    chk("t4_vrhold", a_vr, 1);

    // async reset in the middle of CHANGE
    a_va = 1; tick(); a_clr();
    chk("t6_inchg", a_chr, 1);
    #2 rst = 1;
    #1;
    chk("t6_rst_cr", a_cr, 0);
    chk("t6_rst_outs", {a_acc, a_rej, a_vr, a_chr, a_busy}, 0);
    #1 rst = 0;
    tick();

    // narrow instance: overflow rejection at 5 bits
    b_coin(2'b10);
    chk("t5_cr25", b_cr, 25);
    chk("t5_vr0", b_vr, 0);
    b_coin(2'b10);
    chk("t5_rejC", b_rej, 1);
    chk("t5_cr25b", b_cr, 25);
    b_coin(2'b00);
    chk("t5_acc", b_acc, 1);
    chk("t5_cr30", b_cr, 30);
    b_coin(2'b01);
    chk("t5_rejB", b_rej, 1);
    chk("t5_cr30b", b_cr, 30);

`ifdef VEND_STOCK_EN
    chk("t7_so0", c_so, 0);
    c_cv = 1; c_sel = 2'b01; tick(); c_cv = 0;
    c_cv = 1; c_sel = 2'b00; tick(); c_cv = 0;
    chk("t7_vr", c_vr, 1);
    c_va = 1; tick(); c_va = 0;
    chk("t7_so1", c_so, 1);
    c_cv = 1; c_sel = 2'b00; tick(); c_cv = 0;
    chk("t7_rej", c_rej, 1);
    chk("t7_cr0", c_cr, 0);
    c_rs = 1; tick(); c_rs = 0;
    chk("t7_restock", c_so, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
